// File: rtl/sram_bus_arbiter_if.sv
// sram_bus_arbiter_if: inst/data sram-like request ports and the shared downstream memory port
interface sram_bus_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, rdata,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata
    );

    modport master (
        output inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, rdata,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: one-outstanding arbiter of inst/data requesters onto one sram-like port, data-first with starvation guard
module sram_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic             clk,
    input logic             resetn,
    sram_bus_arbiter_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_e;
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] starve_q, starve_d;
    logic       idle, sel_data, sel_inst, hs, ret;

    // gating with resetn keeps every output quiet while reset is held
    always_comb begin
        idle     = resetn && state_q == IDLE;
        sel_data = idle && bus.data_req && !(bus.inst_req && starve_q == LIM);
        sel_inst = idle && bus.inst_req && !sel_data;
        hs       = (sel_data || sel_inst) && bus.mem_addr_ok;
        ret      = resetn && state_q == WAIT && bus.mem_data_ok;
    end

    assign bus.mem_req      = sel_data | sel_inst;
    assign bus.mem_wr       = sel_data & bus.data_wr;
    assign bus.mem_size     = sel_data ? bus.data_size : sel_inst ? 2'd2 : 2'd0;
    assign bus.mem_addr     = sel_data ? bus.data_addr : sel_inst ? bus.inst_addr : 32'd0;
    assign bus.mem_wstrb    = sel_data ? bus.data_wstrb : 4'd0;
    assign bus.mem_wdata    = sel_data ? bus.data_wdata : 32'd0;
    assign bus.inst_addr_ok = sel_inst & bus.mem_addr_ok;
    assign bus.data_addr_ok = sel_data & bus.mem_addr_ok;
    assign bus.inst_data_ok = ret & ~owner_q;
    assign bus.data_data_ok = ret & owner_q;
    assign bus.rdata        = bus.mem_rdata;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        if (hs) begin
            state_d  = WAIT;
            owner_d  = sel_data;
            starve_d = (sel_data && bus.inst_req) ? (starve_q == LIM ? LIM : starve_q + 4'd1) : 4'd0;
        end
        if (ret)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed plus random checking of sram_bus_arbiter against a transaction-level model and scoreboard
module tb_sram_bus_arbiter;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic resetn;
    int   n_chk = 0;
    int   n_fail = 0;

    sram_bus_arbiter_if bus();
    sram_bus_arbiter #(.STARVE_LIMIT(LIM)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    // model: one transaction in flight, count of data grants won while inst waited
    bit busy = 1'b0;
    int cnt = 0;
    bit inst_acc = 1'b0, data_acc = 1'b0;
    bit sbq[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        bit          want_data, grant_possible, retire;
        logic [71:0] e;
        want_data      = bus.data_req && !(bus.inst_req && cnt == LIM);
        grant_possible = resetn && !busy && (bus.inst_req || bus.data_req);
        retire         = resetn && busy && bus.mem_data_ok;
        if (!grant_possible)
            e = '0;
        else if (want_data)
            e = {1'b1, bus.data_wr, bus.data_size, bus.data_addr, bus.data_wstrb, bus.data_wdata};
        else
            e = {1'b1, 1'b0, 2'd2, bus.inst_addr, 4'd0, 32'd0};
        check("mem_bus", 128'({bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata}), 128'(e));
        check("addr_ok", 128'({bus.inst_addr_ok, bus.data_addr_ok}),
              128'((grant_possible && bus.mem_addr_ok) ? (want_data ? 2'b01 : 2'b10) : 2'b00));
        check("data_ok_any", 128'(bus.inst_data_ok | bus.data_data_ok), 128'(retire));
        check("rdata", 128'(bus.rdata), 128'(bus.mem_rdata));
        inst_acc = 1'b0;
        data_acc = 1'b0;
        if (!resetn) begin
            busy = 1'b0;
            cnt  = 0;
            sbq.delete();
        end else if (grant_possible && bus.mem_addr_ok) begin
            sbq.push_back(want_data);
            cnt      = (want_data && bus.inst_req) ? ((cnt < LIM) ? cnt + 1 : LIM) : 0;
            busy     = 1'b1;
            inst_acc = !want_data;
            data_acc = want_data;
        end else if (retire)
            busy = 1'b0;
    end

    always @(negedge clk) begin
        if (bus.inst_data_ok || bus.data_data_ok) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_underflow: got data_ok %b%b want no response", bus.inst_data_ok, bus.data_data_ok);
            end else begin
                bit o;
                o = sbq.pop_front();
                check("resp_owner", 128'({bus.inst_data_ok, bus.data_data_ok}), 128'(o ? 2'b01 : 2'b10));
            end
        end
    end

    initial begin
        bit grants[$];
        resetn = 1'b0;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1C000000;
        bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_size = 2'd2;
        bus.data_addr = 32'h0; bus.data_wstrb = 4'h0; bus.data_wdata = 32'h0;
        bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'h0;
        repeat (3) begin
            @(negedge clk);
            check("reset_outs", 128'({bus.inst_addr_ok, bus.inst_data_ok, bus.data_addr_ok, bus.data_data_ok,
                  bus.mem_req, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata}), 128'(0));
        end

        nxt(); resetn = 1'b1; bus.data_req = 1'b0;
        @(negedge clk);
        check("inst_grant", 128'({bus.inst_addr_ok, bus.mem_addr, bus.mem_size, bus.mem_wr}), 128'({1'b1, 32'h1C000000, 2'd2, 1'b0}));
        nxt(); bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h02800413;
        @(negedge clk);
        check("inst_ret", 128'({bus.inst_data_ok, bus.data_data_ok, bus.rdata}), 128'({1'b1, 1'b0, 32'h02800413}));

        nxt(); bus.mem_data_ok = 1'b0; bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_size = 2'd0;
        bus.data_addr = 32'h1C010003; bus.data_wstrb = 4'b1000; bus.data_wdata = 32'h5A000000; bus.mem_addr_ok = 1'b1;
        @(negedge clk);
        check("data_fwd", 128'({bus.data_addr_ok, bus.mem_wr, bus.mem_size, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata}),
              128'({1'b1, 1'b1, 2'd0, 32'h1C010003, 4'b1000, 32'h5A000000}));
        nxt(); bus.data_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1;
        @(negedge clk);
        check("data_ret", 128'({bus.inst_data_ok, bus.data_data_ok}), 128'(2'b01));

        nxt(); bus.mem_data_ok = 1'b0; bus.data_req = 1'b1; bus.data_wr = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) bus.inst_req = 1'b1;
            @(negedge clk);
            check("bp_no_ack", 128'({bus.inst_addr_ok, bus.data_addr_ok}), 128'(2'b00));
            nxt();
        end
        bus.mem_addr_ok = 1'b1;
        @(negedge clk);
        check("bp_grant", 128'({bus.inst_addr_ok, bus.data_addr_ok}), 128'(2'b01));
        nxt(); bus.inst_req = 1'b0; bus.data_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1;
        @(negedge clk);

        nxt(); bus.mem_data_ok = 1'b0; bus.inst_req = 1'b1; bus.mem_addr_ok = 1'b1;
        @(negedge clk);
        check("rw_grant", 128'(bus.inst_addr_ok), 128'(1));
        nxt(); bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0; resetn = 1'b0;
        @(negedge clk);
        nxt(); resetn = 1'b1; bus.mem_data_ok = 1'b1;
        @(negedge clk);
        check("rw_late", 128'({bus.inst_data_ok, bus.data_data_ok}), 128'(2'b00));
        nxt(); bus.mem_data_ok = 1'b0; bus.data_req = 1'b1; bus.mem_addr_ok = 1'b1;
        @(negedge clk);
        check("rw_next", 128'(bus.data_addr_ok), 128'(1));
        nxt(); bus.data_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1;
        @(negedge clk);

        nxt(); bus.mem_data_ok = 1'b0; bus.inst_req = 1'b1; bus.data_req = 1'b1; bus.mem_addr_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bit g;
            @(negedge clk);
            check("one_ack", 128'(bus.inst_addr_ok & bus.data_addr_ok), 128'(0));
            g = bus.inst_addr_ok | bus.data_addr_ok;
            if (g) grants.push_back(bus.inst_addr_ok);
            nxt();
            bus.mem_data_ok = g;
        end
        check("order_len", 128'(grants.size()), 128'(10));
        for (int k = 0; k < grants.size(); k++)
            check("order", 128'(grants[k]), 128'((k % (LIM + 1)) == LIM));

        for (int i = 0; i < 4000; i++) begin
            nxt();
            resetn          = ($urandom % 80) != 0;
            bus.mem_addr_ok = ($urandom % 4) != 0;
            bus.mem_data_ok = ($urandom % 3) == 0;
            bus.mem_rdata   = $urandom;
            if (inst_acc || !bus.inst_req) begin
                bus.inst_req  = 1'($urandom);
                bus.inst_addr = $urandom;
            end
            if (data_acc || !bus.data_req) begin
                bus.data_req   = ($urandom % 3) != 0;
                bus.data_wr    = 1'($urandom);
                bus.data_size  = 2'($urandom_range(0, 2));
                bus.data_addr  = $urandom;
                bus.data_wstrb = 4'($urandom);
                bus.data_wdata = $urandom;
            end
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one downstream sram-like memory port between the fetch-stage instruction requester and the EXE/MEM-stage data requester.
- Handles one outstanding transaction at a time; the address phase and the data phase are sequenced by a 2-state FSM.
- Data requests win by default. A starvation counter guarantees the instruction side eventually gets the port.
- Sits between the pipeline's inst_sram/data_sram interfaces and the memory bridge.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants with the instruction request pending, after which the instruction side gets forced priority for one grant. Range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- inst_req  in  1  instruction request
- inst_addr  in  32  instruction address (read only)
- inst_addr_ok  out  1  instruction address accepted
- inst_data_ok  out  1  instruction read data valid
- data_req  in  1  data request
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  data address
- data_wstrb  in  4  byte write strobes
- data_wdata  in  32  write data
- data_addr_ok  out  1  data address accepted
- data_data_ok  out  1  data read returned / write acknowledged
- rdata  out  32  read data, shared by both requesters
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write flag
- mem_size  out  2  downstream size
- mem_addr  out  32  downstream address
- mem_wstrb  out  4  downstream strobes
- mem_wdata  out  32  downstream write data
- mem_addr_ok  in  1  downstream address accepted
- mem_data_ok  in  1  downstream data phase done
- mem_rdata  in  32  downstream read data

Behaviour:
- State
  - FSM states: IDLE, WAIT.
  - owner register: 0 = inst, 1 = data.
  - starve_cnt: 4-bit counter.
- Reset (resetn=0 at posedge)
  - state=IDLE, owner=0, starve_cnt=0.
  - All outputs except rdata are 0 after reset. rdata = mem_rdata, combinational.
  - Reset mid-transaction abandons it; a late mem_data_ok arriving in IDLE is ignored.
- Selection (combinational, IDLE only)
  - sel_data = data_req & ~(inst_req & starve_cnt==STARVE_LIMIT).
  - sel_inst = inst_req & ~sel_data.
- Downstream drive
  - mem_req = IDLE & (inst_req | data_req).
  - When sel_data: mem_wr/size/addr/wstrb/wdata take the data_* inputs.
  - When sel_inst: mem_wr=0, mem_size=2, mem_addr=inst_addr, mem_wstrb=0, mem_wdata=0.
  - In WAIT: mem_req=0; all other mem_* outputs are 0.
- Address handshake
  - inst_addr_ok = IDLE & sel_inst & mem_addr_ok.
  - data_addr_ok = IDLE & sel_data & mem_addr_ok.
  - Both are combinational, same cycle as mem_addr_ok. Never both high.
- Transitions
  - IDLE -> WAIT on mem_req & mem_addr_ok; owner <= sel_data.
  - WAIT -> IDLE on mem_data_ok.
  - mem_addr_ok=0 keeps IDLE, and arbitration is re-evaluated every cycle. A requester must hold its req and fields until addr_ok.
- Data return
  - inst_data_ok = WAIT & mem_data_ok & ~owner.
  - data_data_ok = WAIT & mem_data_ok & owner.
  - Minimum latency: address accepted in cycle N, data_ok earliest in cycle N+1.
  - mem_data_ok in IDLE produces no data_ok.
- Starvation counter (updated on each address handshake)
  - Data granted while inst_req=1: starve_cnt += 1, saturating at STARVE_LIMIT.
  - Inst granted: starve_cnt <= 0.
  - Data granted while inst_req=0: starve_cnt <= 0.
- Simultaneous requests: without starvation, data wins.
- Back-to-back operation: a new request can be granted in the first IDLE cycle after mem_data_ok, giving one transaction per 2 cycles minimum.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with both reqs high -> all outputs except rdata are 0; state IDLE.
- Single inst read: inst_req=1, inst_addr=0x1C000000, mem_addr_ok=1 -> same cycle: mem_addr=0x1C000000, mem_size=2, mem_wr=0, inst_addr_ok=1. Next cycle mem_data_ok=1, mem_rdata=0x02800413 -> inst_data_ok=1, rdata=0x02800413, data_data_ok=0.
- Data write: data_req=1, wr=1, size=0, addr=0x1C010003, wstrb=4'b1000, wdata=0x5A000000 -> fields forwarded; data_addr_ok=1. After mem_data_ok -> data_data_ok=1.
- Collision: both reqs continuously, mem_addr_ok=1, mem_data_ok one cycle after each grant, STARVE_LIMIT=4 -> grant order is D,D,D,D,I,D,D,D,D,I; never two addr_ok in one cycle.
- Backpressure: data_req=1, mem_addr_ok=0 for 5 cycles, inst_req rises at cycle 3 -> no addr_ok and no state change. Once mem_addr_ok=1, data is granted; starve_cnt=1.
- Reset in WAIT: grant inst, assert resetn=0 before mem_data_ok, then mem_data_ok=1 after reset -> inst_data_ok stays 0; next request is granted normally.
